butterfly_pipe: RTL and testbench
=================================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameter N, default 8, meaning FFT size; it SHALL be a power of 2 in the range 2..1024.
REQ-002 Parameter W, default 16, meaning signed input component width.
REQ-003 Parameter TW, default 16, meaning signed twiddle component width; twiddles SHALL be in Q2.(TW-2) format, so 1.0 = 2^(TW-2).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: input pair present.
REQ-007 Port in_ready, output, 1 bit: the block accepts the input pair.
REQ-008 Port xe, input, 2x W bits signed [re, im]: the even input.
REQ-009 Port xo, input, 2x W bits signed [re, im]: the odd input.
REQ-010 Port k, input, KW = max(1, $clog2(N/2)) bits: twiddle index; it SHALL be treated as 0 when N = 2.
REQ-011 Port inverse, input, 1 bit: use the conjugate twiddle; it is sampled per transaction.
REQ-012 Port scale, input, 1 bit: halve the result with rounding; it is sampled per transaction.
REQ-013 Port out_valid, output, 1 bit: the output pair is valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the output pair.
REQ-015 Port x0, output, 2x (W+1) bits signed: the result Xe+G.
REQ-016 Port x1, output, 2x (W+1) bits signed: the result Xe-G.
REQ-017 Port sat_flag, output, 1 bit: sticky flag, set when any saturation occurs.
REQ-018 Port sat_clr, input, 1 bit: synchronous clear of sat_flag.

Function
REQ-019 The twiddle for index k SHALL be (c, s) = round(2^(TW-2)·(cos θ, sin θ)), with θ = -2πk/N. When inverse = 1, s SHALL be negated.
REQ-020 G SHALL be computed as:
- Gre = c·xo.re - s·xo.im
- Gim = c·xo.im + s·xo.re
- each is computed at full precision, rounded half-up by an arithmetic right shift of TW-2, and saturated to W+1 bits.
REQ-021 The outputs SHALL be formed as follows:
- Sums S0 = xe+G and S1 = xe-G SHALL be formed in W+2 bits.
- When scale = 0, each component SHALL be saturated to W+1 bits.
- When scale = 1, each component SHALL be (S+1)>>>1 and SHALL never saturate.
REQ-022 The pipeline SHALL have 3 stages:
- S1 registers the twiddle lookup and the four products.
- S2 registers rounded, saturated G.
- S3 registers x0 and x1.
REQ-023 Latency SHALL be exactly 3 cycles from input acceptance to out_valid when out_ready is held at 1.
REQ-024 The advance signal SHALL be advance = !out_valid || out_ready. All stages SHALL shift only on advance. in_ready SHALL equal advance.
REQ-025 An input pair SHALL be accepted when in_valid && in_ready. A non-accepted cycle SHALL inject a bubble (stage valid = 0).
REQ-026 When out_valid = 1 and out_ready = 0, x0, x1 and all stages SHALL hold unchanged.
REQ-027 Sustained throughput SHALL be 1 pair per cycle while out_ready = 1.
REQ-028 The inverse and scale values SHALL travel with their transaction through the pipeline, independent of later inputs.
REQ-029 sat_flag SHALL be set in the cycle after any saturating transaction leaves S2 or S3. If sat_clr coincides with a new saturation, set SHALL win.

Reset
REQ-030 While rst_n = 0, all stage valids, out_valid and sat_flag SHALL be 0, and x0 and x1 SHALL be 0. The reset SHALL take effect asynchronously and release synchronously to clk.
REQ-031 A reset asserted mid-operation SHALL discard all in-flight pairs. The first accepted pair after release SHALL appear after 3 cycles.

Structure
REQ-032 Package fft_pkg SHALL hold the complex typedef parametrised by width, the twiddle-generation function (elaboration-time $cos/$sin) and the rounding/saturation functions.
REQ-033 The twiddle ROM SHALL be sub-module twiddle_rom #(N, TW) with a registered (k, inverse) -> (c, s) output; the ROM SHALL hold N/2 entries.

Verification
REQ-034 Identity case: N=8, W=16, k=0, xe=(100,50), xo=(20,-10), scale=0, with out_ready held at 1. Required response: x0=(120,40) and x1=(80,60), with out_valid exactly 3 cycles after acceptance.
REQ-035 Quarter-turn twiddle: k=2, xo=(20,-10), xe=(0,0). Required response with inverse=0: x0=(-10,-20). Required response with inverse=1: x0=(10,20).
REQ-036 Saturation: k=1, xe=xo=(32767,32767).
- With scale=0, the required response is x0.re=65535 (saturated), x0.im=32767 and sat_flag=1.
- With scale=1, the required response is x0.re=39553 and no new saturation.
- Pulsing sat_clr SHALL then clear sat_flag.
REQ-037 Backpressure: stream 10 pairs with out_ready toggling 1,0,0,1. Required response: all 10 results arrive in order, with no loss or duplication, and in_ready equals !out_valid || out_ready on every cycle.
REQ-038 Reset mid-stream: assert rst_n=0 with 2 pairs in flight. Required response: out_valid=0 immediately, and neither pair ever appears at the output.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT arithmetic helpers: twiddle generation, rounding and saturation.
package fft_pkg;

  // Full-precision working complex value used for intermediate arithmetic.
  typedef struct packed {
    longint re;
    longint im;
  } cplx_t;

  function automatic int kw_of(int n);
    return (n > 2) ? $clog2(n / 2) : 1;
  endfunction

  // Twiddle component for index k: round(2^(tw-2) * cos/sin(-2*pi*k/n)).
  function automatic int tw_coef(int n, int tw, int k, bit sine);
    real th;
    real one;
    real v;
    th  = -2.0 * 3.14159265358979323846 * real'(k) / real'(n);
    one = real'(longint'(1) <<< (tw - 2));
    v   = sine ? $sin(th) * one : $cos(th) * one;
    return $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
  endfunction

  function automatic longint rnd_shr(longint v, int sh);
    return (v + (longint'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic longint half_rnd(longint v);
    return (v + 64'sd1) >>> 1;
  endfunction

  function automatic longint sat_val(longint v, int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 64'sd1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(longint v, int w);
    return (v > ((longint'(1) <<< (w - 1)) - 64'sd1)) || (v < -(longint'(1) <<< (w - 1)));
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// N/2-entry twiddle table with registered (k, inverse) -> (c, s) lookup.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int  N  = 8,
  parameter int  TW = 16,
  localparam int KW = kw_of(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [KW-1:0]        k,
  input  logic                 inverse,
  output logic signed [TW-1:0] c,
  output logic signed [TW-1:0] s
);

  localparam int NH = N / 2;

  logic signed [TW-1:0] rom_c [NH];
  logic signed [TW-1:0] rom_s [NH];
  logic [KW-1:0]        idx;

  for (genvar i = 0; i < NH; i++) begin : g_rom
    localparam logic signed [TW-1:0] CV = TW'(tw_coef(N, TW, i, 1'b0));
    localparam logic signed [TW-1:0] SV = TW'(tw_coef(N, TW, i, 1'b1));
    assign rom_c[i] = CV;
    assign rom_s[i] = SV;
  end

  assign idx = (N == 2) ? '0 : k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
      s <= '0;
    end else if (en) begin
      c <= rom_c[idx];
      s <= inverse ? -rom_s[idx] : rom_s[idx];
    end
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: X0 = xe + W*xo, X1 = xe - W*xo, with
// optional rounded halving, saturation tracking and ready/valid backpressure.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int  N  = 8,
  parameter int  W  = 16,
  parameter int  TW = 16,
  localparam int KW = kw_of(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   xe,
  input  logic [2*W-1:0]   xo,
  input  logic [KW-1:0]    k,
  input  logic             inverse,
  input  logic             scale,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W+1:0]   x0,
  output logic [2*W+1:0]   x1,
  output logic             sat_flag,
  input  logic             sat_clr
);

  localparam int W1 = W + 1;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cin_t;

  typedef struct packed {
    logic signed [W:0] re;
    logic signed [W:0] im;
  } cout_t;

  logic                 adv;
  logic                 acc;
  logic signed [TW-1:0] c1;
  logic signed [TW-1:0] s1;

  logic  v1, sc1, v2, sc2, gsat2;
  cin_t  xe1, xo1, xe2;
  cout_t g2, g_c, x0_r, x1_r, x0_c, x1_c;
  logic  g_hit, o_hit, new_sat;
  cplx_t g_full, s0, s1w;

  assign adv      = !out_valid || out_ready;
  assign acc      = in_valid && adv;
  assign in_ready = adv;
  assign x0       = x0_r;
  assign x1       = x1_r;

  twiddle_rom #(.N(N), .TW(TW)) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (adv),
    .k      (k),
    .inverse(inverse),
    .c      (c1),
    .s      (s1)
  );

  // The ROM output is the S1 twiddle register, so the four products are
  // formed from S1 registers and folded into the S2 rounding/saturation path.
  always_comb begin
    g_full.re = longint'(c1) * longint'(xo1.re) - longint'(s1) * longint'(xo1.im);
    g_full.im = longint'(c1) * longint'(xo1.im) + longint'(s1) * longint'(xo1.re);
    g_c.re    = W1'(sat_val(rnd_shr(g_full.re, TW - 2), W1));
    g_c.im    = W1'(sat_val(rnd_shr(g_full.im, TW - 2), W1));
    g_hit     = sat_hit(rnd_shr(g_full.re, TW - 2), W1) ||
                sat_hit(rnd_shr(g_full.im, TW - 2), W1);
  end

  always_comb begin
    s0.re  = longint'(xe2.re) + longint'(g2.re);
    s0.im  = longint'(xe2.im) + longint'(g2.im);
    s1w.re = longint'(xe2.re) - longint'(g2.re);
    s1w.im = longint'(xe2.im) - longint'(g2.im);
    o_hit  = 1'b0;
    if (sc2) begin
      x0_c.re = W1'(half_rnd(s0.re));
      x0_c.im = W1'(half_rnd(s0.im));
      x1_c.re = W1'(half_rnd(s1w.re));
      x1_c.im = W1'(half_rnd(s1w.im));
    end else begin
      x0_c.re = W1'(sat_val(s0.re, W1));
      x0_c.im = W1'(sat_val(s0.im, W1));
      x1_c.re = W1'(sat_val(s1w.re, W1));
      x1_c.im = W1'(sat_val(s1w.im, W1));
      o_hit   = sat_hit(s0.re, W1) || sat_hit(s0.im, W1) ||
                sat_hit(s1w.re, W1) || sat_hit(s1w.im, W1);
    end
    new_sat = adv && v2 && (gsat2 || o_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      sc1       <= 1'b0;
      sc2       <= 1'b0;
      gsat2     <= 1'b0;
      xe1       <= '0;
      xo1       <= '0;
      xe2       <= '0;
      g2        <= '0;
      x0_r      <= '0;
      x1_r      <= '0;
    end else begin
      if (adv) begin
        v1        <= acc;
        xe1       <= xe;
        xo1       <= xo;
        sc1       <= scale;
        v2        <= v1;
        xe2       <= xe1;
        g2        <= g_c;
        gsat2     <= g_hit;
        sc2       <= sc1;
        out_valid <= v2;
        x0_r      <= x0_c;
        x1_r      <= x1_c;
      end
      sat_flag <= new_sat || (sat_flag && !sat_clr);
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed self-checking bench for butterfly_pipe (N=8, W=16, TW=16).
module tb_butterfly_pipe;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int TW = 16;
  localparam int KW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  xe;
  logic [2*W-1:0]  xo;
  logic [KW-1:0]   k;
  logic            inverse;
  logic            scale;
  logic            out_valid;
  logic            out_ready;
  logic [2*W+1:0]  x0;
  logic [2*W+1:0]  x1;
  logic            sat_flag;
  logic            sat_clr;

  int tests = 0;
  int fails = 0;

  int             sent;
  int             recv;
  int             seen;
  bit             stalled;
  logic [2*W+1:0] held0;
  logic [2*W+1:0] held1;
  bit             pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  butterfly_pipe #(.N(N), .W(W), .TW(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .xe       (xe),
    .xo       (xo),
    .k        (k),
    .inverse  (inverse),
    .scale    (scale),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x0       (x0),
    .x1       (x1),
    .sat_flag (sat_flag),
    .sat_clr  (sat_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [63:0] re_of(logic [2*W+1:0] v);
    logic signed [W:0] t;
    t = v[2*W+1:W+1];
    return t;
  endfunction

  function automatic logic signed [63:0] im_of(logic [2*W+1:0] v);
    logic signed [W:0] t;
    t = v[W:0];
    return t;
  endfunction

  function automatic logic [2*W-1:0] cp(int re, int im);
    return {16'(re), 16'(im)};
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction; flips inverse/scale right after acceptance so
  // the result must rely on the values carried with the transaction.
  task automatic run1(input string tag, input int er, input int ei, input int orr,
                      input int oi, input int kk, input bit inv, input bit sc,
                      input int e0r, input int e0i, input int e1r, input int e1i);
    int lat;
    xe       = cp(er, ei);
    xo       = cp(orr, oi);
    k        = KW'(kk);
    inverse  = inv;
    scale    = sc;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inverse  = ~inv;
    scale    = ~sc;
    xe       = cp(-1, -1);
    xo       = cp(-1, -1);
    lat      = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_x0re"}, re_of(x0), e0r);
    chk({tag, "_x0im"}, im_of(x0), e0i);
    chk({tag, "_x1re"}, re_of(x1), e1r);
    chk({tag, "_x1im"}, im_of(x1), e1i);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    xe        = '0;
    xo        = '0;
    k         = '0;
    inverse   = 1'b0;
    scale     = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_x0", x0, 0);
    chk("rst_x1", x1, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    run1("ident", 100, 50, 20, -10, 0, 1'b0, 1'b0, 120, 40, 80, 60);
    run1("qturn", 0, 0, 20, -10, 2, 1'b0, 1'b0, -10, -20, 10, 20);
    run1("qturn_inv", 0, 0, 20, -10, 2, 1'b1, 1'b0, 10, 20, -10, -20);
    chk("no_sat_yet", sat_flag, 0);

    run1("sat_s0", 32767, 32767, 32767, 32767, 1, 1'b0, 1'b0, 65535, 32767, -13572, 32767);
    chk("sat_flag_set", sat_flag, 1);
    tick();
    chk("sat_flag_sticky", sat_flag, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_flag_clr", sat_flag, 0);
    run1("sat_s1", 32767, 32767, 32767, 32767, 1, 1'b0, 1'b1, 39553, 16384, -6786, 16384);
    chk("sat_scaled_none", sat_flag, 0);
    sat_clr = 1'b1;
    run1("sat_setwins", 32767, 32767, 32767, 32767, 1, 1'b0, 1'b0, 65535, 32767, -13572, 32767);
    chk("sat_set_wins", sat_flag, 1);
    tick();
    chk("sat_clr_held", sat_flag, 0);
    sat_clr = 1'b0;

    sent    = 0;
    recv    = 0;
    stalled = 1'b0;
    held0   = '0;
    held1   = '0;
    for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 10);
      xe        = cp(sent * 10, sent);
      xo        = cp(sent, -sent);
      k         = '0;
      inverse   = 1'b0;
      scale     = 1'b0;
      #1;
      chk("bp_in_ready", in_ready, !out_valid || out_ready);
      if (stalled) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_x0", x0, held0);
        chk("bp_hold_x1", x1, held1);
      end
      if (out_valid && out_ready) begin
        chk("bp_x0re", re_of(x0), 11 * recv);
        chk("bp_x0im", im_of(x0), 0);
        chk("bp_x1re", re_of(x1), 9 * recv);
        chk("bp_x1im", im_of(x1), 2 * recv);
        recv++;
      end
      stalled = out_valid && !out_ready;
      held0   = x0;
      held1   = x1;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    chk("bp_count", recv, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("bp_no_dup", out_valid, 0);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      xe       = cp(777 + i, 0);
      xo       = cp(0, 0);
      k        = '0;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_x0re", re_of(x0), 777);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_x0", x0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_rst_discard", seen, 0);
    run1("post_rst", 5, 6, 1, 2, 0, 1'b0, 1'b0, 6, 8, 4, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
